// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared widths and state encoding for the program loader.
//               The CSUM state exists only when LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  localparam int IM_ADDR_W = 8;   // instruction-memory address width
  localparam int INSTR_W   = 9;   // instruction word width
  localparam int CNT_W     = 9;   // word counter, holds 1..256

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
`ifdef LOADER_CHECKSUM_EN
    S_ERR   = 3'd6,
    S_CSUM  = 3'd7
`else
    S_ERR   = 3'd6
`endif
  } state_e;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/loader_xsum.sv
`default_nettype none
// ============================================================================
// Module      : loader_xsum
// Description : Byte-wide running XOR accumulator with synchronous clear and
//               enable. Clear has priority over enable.
// Ports       : clk, reset (async active-low), clr_i, en_i, byte_i[7:0],
//               sum_o[7:0] (current accumulated XOR)
// Revision    : 1.0 - initial release
// ============================================================================
module loader_xsum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= 8'h00;
    end else if (clr_i) begin
      sum_q <= 8'h00;
    end else if (en_i) begin
      sum_q <= sum_q ^ byte_i;
    end
  end

  assign sum_o = sum_q;

endmodule : loader_xsum
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Loads a byte stream into instruction memory while holding the
//               core in reset. Stream format: N, then N+1 words as (LO, HI),
//               where HI carries only bit 8 of the word. Optional checksum
//               byte (XOR of all LEN/LO/HI bytes) when LOADER_CHECKSUM_EN is
//               defined.
// Ports       : clk, reset (async active-low)
//               start                      - load request pulse
//               rx_valid, rx_byte, rx_ready - byte stream handshake
//               im_we, im_addr, im_wdata    - instruction-memory write port
//               core_hold                   - holds core in reset (not in DONE)
//               done, error                 - load outcome, sticky until start
// Macro       : LOADER_CHECKSUM_EN enables the CSUM state and loader_xsum.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  output logic                 rx_ready,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [INSTR_W-1:0]   im_wdata,
  output logic                 core_hold,
  output logic                 done,
  output logic                 error
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;        // words still to be written
  logic [IM_ADDR_W-1:0] im_addr_q;
  logic [INSTR_W-1:0]   im_wdata_q;
  logic                 rx_ready_q;
  logic                 im_we_q;
  logic                 core_hold_q;
  logic                 done_q;
  logic                 error_q;

  logic                 w_xfer;
  logic                 w_start_acc;

  // rx_ready is a register, so the handshake never loops through rx_valid.
  assign w_xfer      = rx_valid && rx_ready_q;
  assign w_start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                 (state_q == S_ERR));

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] w_sum;
  logic       w_sum_en;

  assign w_sum_en = w_xfer && ((state_q == S_LEN) || (state_q == S_LO) ||
                               (state_q == S_HI));

  loader_xsum u_xsum (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (w_start_acc),
    .en_i   (w_sum_en),
    .byte_i (rx_byte),
    .sum_o  (w_sum)
  );
`endif

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (w_xfer) state_d = S_LO;
      end
      S_LO: begin
        if (w_xfer) state_d = S_HI;
      end
      S_HI: begin
        // Only bit 0 of the HI byte is meaningful; anything above is a fault.
        if (w_xfer) state_d = (rx_byte[7:1] == 7'd0) ? S_WRITE : S_ERR;
      end
      S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        state_d = (cnt_q == CNT_W'(1)) ? S_CSUM : S_LO;
`else
        state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_LO;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_xfer) state_d = (rx_byte == w_sum) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs decoded from state_d so
  // they line up with the state they describe).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      rx_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
`ifdef LOADER_CHECKSUM_EN
      rx_ready_q  <= (state_d == S_LEN) || (state_d == S_LO) ||
                     (state_d == S_HI)  || (state_d == S_CSUM);
`else
      rx_ready_q  <= (state_d == S_LEN) || (state_d == S_LO) ||
                     (state_d == S_HI);
`endif
      im_we_q     <= (state_d == S_WRITE);
      core_hold_q <= (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERR);

      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_start_acc) begin
            cnt_q     <= '0;
            im_addr_q <= '0;
          end
        end
        S_LEN: begin
          if (w_xfer) cnt_q <= {1'b0, rx_byte} + CNT_W'(1);
        end
        S_LO: begin
          if (w_xfer) im_wdata_q[7:0] <= rx_byte;
        end
        S_HI: begin
          if (w_xfer && (rx_byte[7:1] == 7'd0)) im_wdata_q[8] <= rx_byte[0];
        end
        S_WRITE: begin
          // Address wraps naturally at 256; the counter stops the load first.
          im_addr_q <= im_addr_q + IM_ADDR_W'(1);
          cnt_q     <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign core_hold = core_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Expected memory writes
//               are queued as stimulus is issued; a monitor pops and compares
//               them whenever im_we is seen. Checksum bytes are appended when
//               LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_ready;
  logic       im_we;
  logic [7:0] im_addr;
  logic [8:0] im_wdata;
  logic       core_hold;
  logic       done;
  logic       error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] exp_q[$];   // {addr, data}
  logic [16:0] mon_e;
  logic [7:0]  xsum;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every im_we must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && im_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 im_addr, im_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write", {15'd0, im_addr, im_wdata}, {15'd0, mon_e});
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xsum = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready_timeout: got rx_ready 0 expected 1 for byte 0x%0h", b);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
    xsum = xsum ^ b;
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [8:0] w);
    exp_q.push_back({addr, w});
    send(w[7:0]);
    send({7'd0, w[8]});
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic finish_ok(input string name, input logic [7:0] exp_addr);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = xsum;
    send(c);
`endif
    wait_end();
    chk({name, "_done"},  {31'd0, done},      32'd1);
    chk({name, "_error"}, {31'd0, error},     32'd0);
    chk({name, "_hold"},  {31'd0, core_hold}, 32'd0);
    chk({name, "_addr"},  {24'd0, im_addr},   {24'd0, exp_addr});
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_hold"},   {31'd0, core_hold}, 32'd1);
    chk({name, "_ready"},  {31'd0, rx_ready},  32'd0);
    chk({name, "_we"},     {31'd0, im_we},     32'd0);
    chk({name, "_addr"},   {24'd0, im_addr},   32'd0);
    chk({name, "_wdata"},  {23'd0, im_wdata},  32'd0);
    chk({name, "_done"},   {31'd0, done},      32'd0);
    chk({name, "_error"},  {31'd0, error},     32'd0);
  endtask

  initial begin
    xsum = 8'h00;
    // Reset state
    #12;
    chk_reset_outs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Basic load: N=1, words 0x134 and 0x0AB
    pulse_start();
    send(8'h01);
    send_word(8'd0, 9'h134);
    send_word(8'd1, 9'h0AB);
    finish_ok("basic", 8'd2);

    // Back-pressure between LO and HI
    pulse_start();
    send(8'h00);
    exp_q.push_back({8'd0, 9'h15A});
    send(8'h5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_wdata_hold", {24'd0, im_wdata[7:0]}, 32'h5A);
    end
    send(8'h01);
    finish_ok("bp", 8'd1);

    // Format fault in HI byte
    pulse_start();
    send(8'h00);
    send(8'h12);
    send(8'h02);
    wait_end();
    chk("fmt_error", {31'd0, error},     32'd1);
    chk("fmt_hold",  {31'd0, core_hold}, 32'd1);
    chk("fmt_done",  {31'd0, done},      32'd0);

    // Wrap: 256 words
    pulse_start();
    send(8'hFF);
    for (int i = 0; i < 256; i++) send_word(8'(i), 9'(i));
    finish_ok("wrap", 8'd0);

    // Reset during a load, just after the HI byte of the third word
    pulse_start();
    send(8'h04);
    send_word(8'd0, 9'h101);
    send_word(8'd1, 9'h022);
    send(8'h33);
    send(8'h01);
    reset = 1'b0;
    #2;
    chk_reset_outs("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_pending", exp_q.size(), 32'd0);
    pulse_start();
    send(8'h01);
    send_word(8'd0, 9'h1C3);
    send_word(8'd1, 9'h07E);
    finish_ok("after_rst", 8'd2);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match
    pulse_start();
    send(8'h00);
    send_word(8'd0, 9'h005);
    send(8'h05);
    wait_end();
    chk("csum_ok_done",  {31'd0, done},  32'd1);
    chk("csum_ok_error", {31'd0, error}, 32'd0);
    // Checksum mismatch
    pulse_start();
    send(8'h00);
    send_word(8'd0, 9'h005);
    send(8'h04);
    wait_end();
    chk("csum_bad_error", {31'd0, error},     32'd1);
    chk("csum_bad_done",  {31'd0, done},      32'd0);
    chk("csum_bad_hold",  {31'd0, core_hold}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    chk("all_writes_seen", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_prog_loader
`default_nettype wire
